alu_cmd_driver: RTL

Command-side front end for the registered 4-bit ALU. Accepts one operation at a time from a valid/ready command port, drives the ALU operand, opcode and carry/borrow inputs, and holds them stable through the ALU's two-register latency. Captures the ALU's 5-bit result and flags. Returns them with the command tag on a valid/ready response port, and keeps wrap-around operation and overflow counters. It sits between the controller/sequencer and the ALU instance and shares that instance's clock and reset.

---
 rtl/alu_cmd_driver.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/alu_cmd_driver.sv
// Command-side front end for the registered 4-bit ALU: accepts one command at a time,
// holds the ALU inputs through its two-register latency and returns result/flags with the tag.
module alu_cmd_driver #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [3:0]       cmd_op,
  input  logic             cmd_ci,
  input  logic             cmd_bi,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_ci,
  output logic             alu_bi,
  input  logic [4:0]       alu_result,
  input  logic             alu_sign,
  input  logic             alu_zero,
  input  logic             alu_parity,
  input  logic             alu_ovf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [4:0]       rsp_result,
  output logic             rsp_sign,
  output logic             rsp_zero,
  output logic             rsp_parity,
  output logic             rsp_ovf,
  output logic             rsp_illegal,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] ovf_count
);

  typedef enum logic [2:0] {IDLE, ISSUE, EXEC, CAPT, RESP} state_e;

  state_e           state_q, state_d;
  logic [3:0]       a_q, a_d, b_q, b_d, op_q, op_d;
  logic             ci_q, ci_d, bi_q, bi_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [4:0]       res_q, res_d;
  logic [3:0]       flags_q, flags_d;   // {sign, zero, parity, ovf}
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] op_cnt_q, op_cnt_d, ovf_cnt_q, ovf_cnt_d;

  assign cmd_ready = (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    ci_d        = ci_q;
    bi_d        = bi_q;
    tag_d       = tag_q;
    rsp_valid_d = rsp_valid_q;
    res_d       = res_q;
    flags_d     = flags_q;
    illegal_d   = illegal_q;
    op_cnt_d    = op_cnt_q;
    ovf_cnt_d   = ovf_cnt_q;
    case (state_q)
      IDLE: begin
        // ALU inputs only change here, so they stay put until the next accept
        if (cmd_valid) begin
          a_d     = cmd_a;
          b_d     = cmd_b;
          op_d    = cmd_op;
          ci_d    = cmd_ci;
          bi_d    = cmd_bi;
          tag_d   = cmd_tag;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = EXEC;
      EXEC:  state_d = CAPT;
      CAPT: begin
        res_d       = alu_result;
        flags_d     = {alu_sign, alu_zero, alu_parity, alu_ovf};
        illegal_d   = op_q[3] & op_q[2];
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_cnt_d    = op_cnt_q + CNT_W'(1);
          if (flags_q[0]) ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      ci_q        <= 1'b0;
      bi_q        <= 1'b0;
      tag_q       <= '0;
      rsp_valid_q <= 1'b0;
      res_q       <= '0;
      flags_q     <= '0;
      illegal_q   <= 1'b0;
      op_cnt_q    <= '0;
      ovf_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      ci_q        <= ci_d;
      bi_q        <= bi_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
      illegal_q   <= illegal_d;
      op_cnt_q    <= op_cnt_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;
  assign alu_ci      = ci_q;
  assign alu_bi      = bi_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_tag     = tag_q;
  assign rsp_result  = res_q;
  assign rsp_sign    = flags_q[3];
  assign rsp_zero    = flags_q[2];
  assign rsp_parity  = flags_q[1];
  assign rsp_ovf     = flags_q[0];
  assign rsp_illegal = illegal_q;
  assign op_count    = op_cnt_q;
  assign ovf_count   = ovf_cnt_q;

endmodule
